// File: rtl/csa_mul_seq_if.sv
// Start/done handshake and operand/product bus for csa_mul_seq.
// master: requester side (drives start/a/b). slave: multiplier side.
interface csa_mul_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input p);
  modport slave  (input  start, input  a,    input b,
                  output busy,  output done, output p);
endinterface

// File: rtl/csa_mul_seq.sv
// csa_mul_seq: iterative unsigned multiplier built around one carry-save
// adder row. The running product is kept as redundant sum/carry words; one
// partial product is folded in per ACCUM cycle, and a single carry-propagate
// add in RESOLVE produces the high half of the product.
// Optional feature macro: CSA_MUL_EARLY_EXIT_EN -- ACCUM stops after the
// highest set bit of b and RESOLVE realigns the result with a barrel shift.
module csa_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  csa_mul_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   pp;
  logic [WIDTH-1:0]   row_s;
  logic [WIDTH-1:0]   row_c;
  logic [WIDTH-1:0]   high;
  logic [CW-1:0]      iter_load;

`ifdef CSA_MUL_EARLY_EXIT_EN
  logic [CW-1:0]      shamt_q, shamt_d;
  logic [CW-1:0]      k_len;
  logic [2*WIDTH-1:0] resolved;

  // Iteration count k = max(1, index of highest set bit of b + 1).
  always_comb begin
    k_len = CW'(1);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.b[i]) k_len = CW'(i + 1);
    end
  end

  // Only k product bits were shifted into the top of lo_q; shifting the
  // concatenation right by WIDTH-k puts them back at weight 2^0.
  always_comb begin
    resolved = {high, lo_q} >> shamt_q;
  end

  assign iter_load = k_len - CW'(1);
`else
  assign iter_load = CW'(WIDTH - 1);
`endif

  // One CSA row plus the final carry-propagate add of the redundant pair.
  always_comb begin
    pp    = b_q[0] ? a_q : '0;
    row_s = s_q ^ c_q ^ pp;
    row_c = (s_q & c_q) | (s_q & pp) | (c_q & pp);
    high  = s_q + c_q;
  end

  // Next-state and datapath update for the IDLE/ACCUM/RESOLVE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
`ifdef CSA_MUL_EARLY_EXIT_EN
    shamt_d = shamt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          s_d     = '0;
          c_d     = '0;
          lo_d    = '0;
          cnt_d   = iter_load;
`ifdef CSA_MUL_EARLY_EXIT_EN
          shamt_d = CW'(WIDTH) - k_len;
`endif
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // b_q is consumed LSB first by shifting, so b_q[0] is always bit i.
        lo_d  = {row_s[0], lo_q[WIDTH-1:1]};
        s_d   = {1'b0, row_s[WIDTH-1:1]};
        c_d   = row_c;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = RESOLVE;
      end
      RESOLVE: begin
`ifdef CSA_MUL_EARLY_EXIT_EN
        p_d = resolved;
`else
        p_d = {high, lo_q};
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
`ifdef CSA_MUL_EARLY_EXIT_EN
      shamt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
`ifdef CSA_MUL_EARLY_EXIT_EN
      shamt_q <= shamt_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule
